// File: rtl/calc_ctrl_p_if.sv
// ============================================================================
// Module   : calc_ctrl_p_if
// Desc     : Token-class flags, stack status and control strobes of the
//            infix expression evaluator control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_ctrl_p_if #(
  parameter int MAX_DIGITS = 3,
  parameter int CNT_W      = 2
);
  logic                  start;
  logic                  is_operand;
  logic                  is_operator;
  logic                  is_lparen;
  logic                  is_rparen;
  logic                  is_hash;
  logic                  is_lt;
  logic                  optr_empty;
  logic                  optr_top_lparen;
  logic                  opnd_full;
  logic                  optr_full;

  logic [MAX_DIGITS-1:0] num_en;
  logic                  index_cnt;
  logic                  num_clr;
  logic                  stk_clr;
  logic                  sel;
  logic                  operand_push;
  logic                  operand_pop;
  logic                  operator_push;
  logic                  operator_pop;
  logic                  op1_en;
  logic                  op2_en;
  logic                  operator_en;
  logic                  result_en;
  logic [CNT_W-1:0]      mode;
  logic                  done;
  logic                  error;
  logic [1:0]            err_code;
  logic [3:0]            state;

  modport master (
    output start, is_operand, is_operator, is_lparen, is_rparen, is_hash,
           is_lt, optr_empty, optr_top_lparen, opnd_full, optr_full,
    input  num_en, index_cnt, num_clr, stk_clr, sel, operand_push,
           operand_pop, operator_push, operator_pop, op1_en, op2_en,
           operator_en, result_en, mode, done, error, err_code, state
  );

  modport slave (
    input  start, is_operand, is_operator, is_lparen, is_rparen, is_hash,
           is_lt, optr_empty, optr_top_lparen, opnd_full, optr_full,
    output num_en, index_cnt, num_clr, stk_clr, sel, operand_push,
           operand_pop, operator_push, operator_pop, op1_en, op2_en,
           operator_en, result_en, mode, done, error, err_code, state
  );
endinterface

`default_nettype wire

// File: rtl/calc_ctrl_p.sv
// ============================================================================
// Module   : calc_ctrl_p
// Desc     : Control FSM for a two-stack infix expression evaluator
//            (digit assembly, operator precedence, 5-cycle reduce).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_ctrl_p #(
  parameter int MAX_DIGITS = 3,
  parameter int CNT_W      = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  calc_ctrl_p_if.slave   bus
);

  localparam logic [3:0] c_idle     = 4'd0;
  localparam logic [3:0] c_init     = 4'd1;
  localparam logic [3:0] c_scan     = 4'd2;
  localparam logic [3:0] c_digit    = 4'd3;
  localparam logic [3:0] c_numpush  = 4'd4;
  localparam logic [3:0] c_oppush   = 4'd5;
  localparam logic [3:0] c_popparen = 4'd6;
  localparam logic [3:0] c_r1       = 4'd7;
  localparam logic [3:0] c_r2       = 4'd8;
  localparam logic [3:0] c_r3       = 4'd9;
  localparam logic [3:0] c_r4       = 4'd10;
  localparam logic [3:0] c_r5       = 4'd11;
  localparam logic [3:0] c_done     = 4'd12;
  localparam logic [3:0] c_err      = 4'd13;

  localparam logic [1:0] c_err_digit = 2'd1;
  localparam logic [1:0] c_err_paren = 2'd2;
  localparam logic [1:0] c_err_stack = 2'd3;

  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_err_code;

  logic [3:0]       w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [1:0]       w_err_nxt;
  logic             w_tok_any;

  // Any non-operand token terminates a pending number first.
  assign w_tok_any = bus.is_operator | bus.is_lparen | bus.is_rparen | bus.is_hash;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_err_nxt   = r_err_code;
    case (r_state)
      c_idle: begin
        if (bus.start) w_state_nxt = c_init;
      end
      c_init: begin
        w_count_nxt = '0;
        w_state_nxt = c_scan;
      end
      c_scan: begin
        if (bus.is_operand) begin
          if (r_count == c_max_cnt) begin
            w_state_nxt = c_err;
            w_err_nxt   = c_err_digit;
          end else begin
            w_state_nxt = c_digit;
          end
        end else if (w_tok_any && (r_count != '0)) begin
          if (bus.opnd_full) begin
            w_state_nxt = c_err;
            w_err_nxt   = c_err_stack;
          end else begin
            w_state_nxt = c_numpush;
          end
        end else if (bus.is_operator) begin
          if (!bus.optr_empty && !bus.optr_top_lparen && bus.is_lt) begin
            w_state_nxt = c_r1;
          end else if (bus.optr_full) begin
            w_state_nxt = c_err;
            w_err_nxt   = c_err_stack;
          end else begin
            w_state_nxt = c_oppush;
          end
        end else if (bus.is_lparen) begin
          if (bus.optr_full) begin
            w_state_nxt = c_err;
            w_err_nxt   = c_err_stack;
          end else begin
            w_state_nxt = c_oppush;
          end
        end else if (bus.is_rparen) begin
          if (bus.optr_top_lparen) begin
            w_state_nxt = c_popparen;
          end else if (bus.optr_empty) begin
            w_state_nxt = c_err;
            w_err_nxt   = c_err_paren;
          end else begin
            w_state_nxt = c_r1;
          end
        end else if (bus.is_hash) begin
          if (bus.optr_empty) begin
            w_state_nxt = c_done;
          end else if (bus.optr_top_lparen) begin
            w_state_nxt = c_err;
            w_err_nxt   = c_err_paren;
          end else begin
            w_state_nxt = c_r1;
          end
        end
      end
      c_digit: begin
        w_count_nxt = r_count + c_cnt_one;
        w_state_nxt = c_scan;
      end
      c_numpush: begin
        w_count_nxt = '0;
        w_state_nxt = c_scan;
      end
      c_oppush, c_popparen: w_state_nxt = c_scan;
      c_r1:                 w_state_nxt = c_r2;
      c_r2:                 w_state_nxt = c_r3;
      c_r3:                 w_state_nxt = c_r4;
      c_r4:                 w_state_nxt = c_r5;
      c_r5:                 w_state_nxt = c_scan;
      c_done, c_err: begin
        if (bus.start) w_state_nxt = c_init;
      end
      default:              w_state_nxt = c_idle;
    endcase
    // Error code is cleared on entry to INIT so it is already 0 there.
    if (w_state_nxt == c_init) w_err_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_idle;
      r_count    <= '0;
      r_err_code <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_err_code <= w_err_nxt;
    end
  end

  always_comb begin
    bus.num_en        = '0;
    bus.index_cnt     = 1'b0;
    bus.num_clr       = 1'b0;
    bus.stk_clr       = 1'b0;
    bus.sel           = 1'b0;
    bus.operand_push  = 1'b0;
    bus.operand_pop   = 1'b0;
    bus.operator_push = 1'b0;
    bus.operator_pop  = 1'b0;
    bus.op1_en        = 1'b0;
    bus.op2_en        = 1'b0;
    bus.operator_en   = 1'b0;
    bus.result_en     = 1'b0;
    bus.mode          = '0;
    bus.done          = 1'b0;
    bus.error         = 1'b0;
    case (r_state)
      c_init: begin
        bus.stk_clr = 1'b1;
        bus.num_clr = 1'b1;
      end
      c_scan:     bus.num_clr = (r_count == '0);
      c_digit: begin
        bus.num_en    = MAX_DIGITS'(1) << r_count;
        bus.index_cnt = 1'b1;
      end
      c_numpush: begin
        bus.operand_push = 1'b1;
        bus.mode         = r_count - c_cnt_one;
      end
      c_oppush: begin
        bus.operator_push = 1'b1;
        bus.index_cnt     = 1'b1;
      end
      c_popparen: begin
        bus.operator_pop = 1'b1;
        bus.index_cnt    = 1'b1;
      end
      c_r1: begin
        bus.op2_en      = 1'b1;
        bus.operator_en = 1'b1;
      end
      c_r2: begin
        bus.operand_pop  = 1'b1;
        bus.operator_pop = 1'b1;
      end
      c_r3:       bus.op1_en = 1'b1;
      c_r4: begin
        bus.operand_pop = 1'b1;
        bus.result_en   = 1'b1;
      end
      c_r5: begin
        bus.sel          = 1'b1;
        bus.operand_push = 1'b1;
      end
      c_done:     bus.done  = 1'b1;
      c_err:      bus.error = 1'b1;
      default: ;
    endcase
  end

  assign bus.err_code = r_err_code;
  assign bus.state    = r_state;

endmodule

`default_nettype wire
